ras_restore_queue: RTL and testbench
====================================

// Module: ras_restore_queue
// PURPOSE
//  Records every return address the RAS pops speculatively in fetch, in program order.
//  Entries retire as the matching returns resolve in order in execute.
//  On a pipeline flush, replays all unresolved entries into ras.restore_i, youngest first.
//  Replay re-pushes wrong-path pops and returns the RAS to its pre-speculation top.
//  Sits in stage01_fetch beside the RAS; its restore_o drives the RAS restore input.
// PARAMETERS
//  DEPTH  8                    max unresolved speculative pops tracked; power of two, >=2
//  XLEN   ceres_param::XLEN    address width carried in ras_t.data
// PORTS
//  clk_i        in   1        clock; all state updates on rising edge
//  rst_i        in   1        reset; asynchronous, active-high
//  pop_valid_i  in   1        RAS popped an entry this cycle (ras.popped_o.valid & fetch accepted)
//  pop_data_i   in   ras_t    the popped entry (ras.popped_o)
//  resolve_i    in   1        oldest predicted return resolved (correct or not); retires head
//  flush_i      in   1        pipeline flush; all unresolved pops are wrong-path
//  restore_o    out  ras_t    one entry per cycle to ras.restore_i; .valid qualifies it
//  busy_o       out  1        replay in progress; fetch must hold req_valid to RAS low
//  full_o       out  1        count == DEPTH
//  count_o      out  $clog2(DEPTH)+1  unresolved entries held
// BEHAVIOUR
//  Reset (async, while rst_i=1): state=IDLE, wr_ptr=rd_ptr=0, count=0, restore_o='0, busy_o=0, full_o=0.
//  Storage is a circular buffer of DEPTH ras_t. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally.
//  States:
//   IDLE     normal tracking
//   RESTORE  replaying; left when the replay count reaches 0
//  IDLE, per cycle, in this order:
//   (a) resolve_i & count>0: rd_ptr++, count--. resolve_i with count==0 is ignored.
//   (b) pop_valid_i: buf[wr_ptr]<=pop_data_i (valid forced 1), wr_ptr++, count++.
//       If full after (a): overwrite the oldest entry (rd_ptr++ too, count unchanged); RAS is lossy anyway.
//   (c) flush_i: if count after (a),(b) is >0, go to RESTORE with that count; else stay IDLE.
//       A same-cycle pop is included in the replay.
//  RESTORE, per cycle:
//   restore_o = {data: buf[wr_ptr-1].data, valid: 1}.
//   Then wr_ptr--, count--; when count becomes 0, return to IDLE (rd_ptr == wr_ptr then).
//   pop_valid_i, resolve_i and flush_i are ignored; an assertion flags pop_valid_i or resolve_i.
//  Latency: first restore_o.valid is one cycle after flush_i. N entries take N consecutive cycles.
//  restore_o is registered from state and buffer. It is '0 in IDLE.
//  busy_o = (state==RESTORE). full_o and count_o reflect registered state.
//  Youngest-first replay: the RAS shifts down on restore, so the oldest popped entry ends on top.
//  Reset mid-replay aborts immediately; the RAS is also reset, so nothing is left stale.
// CONFIGURATION
//  RAS_RQ_STATS_EN defined: adds ports stat_overflow_o[31:0] and stat_restored_o[31:0].
//   stat_overflow_o counts oldest-entry overwrites. stat_restored_o counts restore_o.valid cycles.
//   Both saturate at all-ones and reset to 0.
//  RAS_RQ_STATS_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  ceres_param gains:
//   RAS_RQ_DEPTH (default 8), used as DEPTH.
//   typedef enum logic {RQ_IDLE, RQ_RESTORE} ras_rq_state_e.
//  ras_t is reused unchanged from ceres_param.
//  Single module; no sub-module is natural (pointer logic is ~20 lines).
//  Top-level glue ORs busy_o into the fetch stall.
// TESTING
//  1 pops A=0x100,B=0x200 then flush -> restore_o.valid 2 cycles: 0x200 then 0x100; busy_o=1 both; count_o 2->0.
//  2 pops A,B; resolve; flush -> one restore of B (0x200) only; A retired, not replayed.
//  3 pop C, resolve and flush in one cycle with count=1 (A) -> A retired, C enqueued, replay C only.
//  4 DEPTH+1 pops 0x10..0x90 with no resolve -> full_o=1, oldest 0x10 overwritten; flush replays 0x90..0x20 (8 cycles).
//  5 flush with count=0 -> no restore_o.valid, busy_o stays 0; resolve with count=0 -> count stays 0.
//  6 rst_i asserted mid-replay (after 1 of 3) -> restore_o='0, busy_o=0, count_o=0 asynchronously; idle after release.

Source files
------------

// File: rtl/ras_restore_queue_pkg.sv
// Shared types and constants for the RAS restore queue.
// Holds the return-address entry type, the queue depth and the FSM state enum.
package ras_restore_queue_pkg;

   localparam int XLEN         = 32;
   localparam int RAS_RQ_DEPTH = 8;

   // One return-stack entry; valid qualifies data
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] data;
   } ras_t;

   typedef enum logic {RQ_IDLE, RQ_RESTORE} ras_rq_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ras_restore_queue_if.sv
// Bundle between fetch/RAS glue and the RAS restore queue.
// When RAS_RQ_STATS_EN is defined, the statistics counters are carried here too.
interface ras_restore_queue_if
   import ras_restore_queue_pkg::*;
   #(parameter int DEPTH = RAS_RQ_DEPTH) ();

   logic                     pop_valid_i;
   ras_t                     pop_data_i;
   logic                     resolve_i;
   logic                     flush_i;
   ras_t                     restore_o;
   logic                     busy_o;
   logic                     full_o;
   logic [$clog2(DEPTH):0]   count_o;
`ifdef RAS_RQ_STATS_EN
   logic [31:0]              stat_overflow_o;
   logic [31:0]              stat_restored_o;
`endif

   // Fetch side: reports pops, resolutions and flushes; consumes the replay
   modport master (
      output pop_valid_i, pop_data_i, resolve_i, flush_i,
`ifdef RAS_RQ_STATS_EN
      input  stat_overflow_o, stat_restored_o,
`endif
      input  restore_o, busy_o, full_o, count_o
   );

   // Queue side
   modport slave (
      input  pop_valid_i, pop_data_i, resolve_i, flush_i,
`ifdef RAS_RQ_STATS_EN
      output stat_overflow_o, stat_restored_o,
`endif
      output restore_o, busy_o, full_o, count_o
   );

endinterface

// File: rtl/ras_restore_queue.sv
// RAS restore queue: remembers every speculatively popped return address in
// program order, retires them as returns resolve, and on a flush replays the
// unresolved ones youngest-first into the RAS restore input so the stack
// returns to its pre-speculation top.
// Optional build macro RAS_RQ_STATS_EN adds saturating overflow/restore counters.
module ras_restore_queue
   import ras_restore_queue_pkg::*;
   #(parameter int DEPTH = RAS_RQ_DEPTH)
   (
      input logic                clk_i,
      input logic                rst_i,
      ras_restore_queue_if.slave rq
   );

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   ras_rq_state_e  state;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   ras_t           restore_q;
   ras_t           entries [DEPTH];

   logic [PW-1:0]  wr_prev;
   logic [PW-1:0]  wr_after;
   logic [PW-1:0]  rd_after;
   logic [CW-1:0]  cnt_resolved;
   logic [CW-1:0]  cnt_after;
   logic           overwrite;
   logic           do_pop;
   ras_t           youngest;

   // Next pointers/count while tracking: resolve first, then pop, oldest lost on overflow
   always_comb begin
      wr_prev      = wr_ptr - PTR_ONE;
      rd_after     = rd_ptr;
      cnt_resolved = count;
      if (rq.resolve_i && (count != '0)) begin
         rd_after     = rd_ptr + PTR_ONE;
         cnt_resolved = count - CNT_ONE;
      end
      do_pop    = (state == RQ_IDLE) && rq.pop_valid_i;
      overwrite = do_pop && (cnt_resolved == FULL_CNT);
      cnt_after = cnt_resolved;
      wr_after  = wr_ptr;
      if (do_pop) begin
         wr_after = wr_ptr + PTR_ONE;
         if (overwrite) begin
            rd_after = rd_after + PTR_ONE;
         end else begin
            cnt_after = cnt_resolved + CNT_ONE;
         end
      end
      youngest = entries[wr_prev];
      if (do_pop) begin
         youngest.valid = 1'b1;
         youngest.data  = rq.pop_data_i.data;
      end
   end

   // Entry storage; valid is forced so replayed entries are always qualified
   always_ff @(posedge clk_i) begin
      if (do_pop) begin
         entries[wr_ptr].valid <= 1'b1;
         entries[wr_ptr].data  <= rq.pop_data_i.data;
      end
   end

   // Tracking/replay FSM; the flush cycle already loads the youngest entry so replay starts next cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= RQ_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         restore_q <= '0;
      end else begin
         case (state)
            RQ_IDLE: begin
               rd_ptr <= rd_after;
               if (rq.flush_i && (cnt_after != '0)) begin
                  state           <= RQ_RESTORE;
                  restore_q.valid <= 1'b1;
                  restore_q.data  <= youngest.data;
                  wr_ptr          <= wr_after - PTR_ONE;
                  count           <= cnt_after - CNT_ONE;
               end else begin
                  wr_ptr    <= wr_after;
                  count     <= cnt_after;
                  restore_q <= '0;
               end
            end
            RQ_RESTORE: begin
               if (count != '0) begin
                  restore_q.valid <= 1'b1;
                  restore_q.data  <= entries[wr_prev].data;
                  wr_ptr          <= wr_prev;
                  count           <= count - CNT_ONE;
               end else begin
                  state     <= RQ_IDLE;
                  restore_q <= '0;
               end
            end
            default: begin
               state     <= RQ_IDLE;
               restore_q <= '0;
            end
         endcase
      end
   end

   assign rq.restore_o = restore_q;
   assign rq.busy_o    = (state == RQ_RESTORE);
   assign rq.full_o    = (count == FULL_CNT);
   assign rq.count_o   = count;

`ifdef RAS_RQ_STATS_EN
   logic [31:0] stat_overflow;
   logic [31:0] stat_restored;

   // Saturating counters of lost oldest entries and replayed entries
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_overflow <= '0;
         stat_restored <= '0;
      end else begin
         if (overwrite) begin
            stat_overflow <= sat_inc(stat_overflow);
         end
         if (restore_q.valid) begin
            stat_restored <= sat_inc(stat_restored);
         end
      end
   end

   assign rq.stat_overflow_o = stat_overflow;
   assign rq.stat_restored_o = stat_restored;
`endif

   // Fetch must hold pops and resolutions off while the replay owns the RAS
   a_quiet_during_restore: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (state == RQ_RESTORE) |-> !(rq.pop_valid_i || rq.resolve_i)
   );

endmodule

// File: tb/tb_ras_restore_queue.sv
// Scoreboard bench for ras_restore_queue: expected replay addresses are queued
// when a flush is driven and compared as restore_o.valid cycles appear.
module tb_ras_restore_queue;
   import ras_restore_queue_pkg::*;

   logic clk_i;
   logic rst_i;
   int   errors;
   int   checks;
   int   pushedTotal;
   logic [XLEN-1:0] sb [$];

   ras_restore_queue_if rq ();

   ras_restore_queue dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .rq    (rq.slave)
   );

   // 10 ns clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then return them to idle
   task automatic applyStimulus(input logic pop, input logic [XLEN-1:0] addr,
                                input logic res, input logic fl);
      rq.pop_valid_i     = pop;
      rq.pop_data_i.valid = pop;
      rq.pop_data_i.data = addr;
      rq.resolve_i       = res;
      rq.flush_i         = fl;
      @(posedge clk_i);
      #1;
      rq.pop_valid_i     = 1'b0;
      rq.pop_data_i      = '0;
      rq.resolve_i       = 1'b0;
      rq.flush_i         = 1'b0;
   endtask

   task automatic expectRestore(input logic [XLEN-1:0] addr);
      sb.push_back(addr);
      pushedTotal++;
   endtask

   // Bounded wait for the replay to finish, then the scoreboard must be drained
   task automatic waitIdle(input string tag);
      for (int i = 0; i < 20 && rq.busy_o; i++) begin
         @(posedge clk_i);
         #1;
      end
      checkOutput({tag, "_done"}, 64'(rq.busy_o), 64'd0);
      checkOutput({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      checkOutput({tag, "_count"}, 64'(rq.count_o), 64'd0);
   endtask

   // Monitor: every valid restore must match the next expected address
   always @(negedge clk_i) begin
      if (rq.restore_o.valid) begin
         if (sb.size() == 0) begin
            checkOutput("restore_unexpected", 64'(rq.restore_o.data), 64'hdead_beef_dead_beef);
         end else begin
            checkOutput("restore_data", 64'(rq.restore_o.data), 64'(sb.pop_front()));
            checkOutput("busy_with_restore", 64'(rq.busy_o), 64'd1);
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      pushedTotal = 0;
      rq.pop_valid_i = 1'b0;
      rq.pop_data_i  = '0;
      rq.resolve_i   = 1'b0;
      rq.flush_i     = 1'b0;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset_restore", 64'(rq.restore_o), 64'd0);
      checkOutput("reset_busy", 64'(rq.busy_o), 64'd0);
      checkOutput("reset_full", 64'(rq.full_o), 64'd0);
      checkOutput("reset_count", 64'(rq.count_o), 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // 1: two pops then flush, replay youngest first
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
      checkOutput("t1_count", 64'(rq.count_o), 64'd2);
      expectRestore(32'h200);
      expectRestore(32'h100);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t1_busy", 64'(rq.busy_o), 64'd1);
      waitIdle("t1");

      // 2: resolve retires the oldest, only B replays
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t2_count", 64'(rq.count_o), 64'd1);
      expectRestore(32'h200);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      waitIdle("t2");

      // 3: pop, resolve and flush in one cycle
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
      checkOutput("t3_count", 64'(rq.count_o), 64'd1);
      expectRestore(32'h300);
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
      checkOutput("t3_busy", 64'(rq.busy_o), 64'd1);
      waitIdle("t3");

      // 4: overflow drops 0x10, replay 0x90 down to 0x20
      for (int i = 1; i <= RAS_RQ_DEPTH + 1; i++) begin
         applyStimulus(1'b1, 32'(i * 16), 1'b0, 1'b0);
      end
      checkOutput("t4_full", 64'(rq.full_o), 64'd1);
      checkOutput("t4_count", 64'(rq.count_o), 64'(RAS_RQ_DEPTH));
      for (int i = RAS_RQ_DEPTH + 1; i >= 2; i--) begin
         expectRestore(32'(i * 16));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      waitIdle("t4");
      checkOutput("t4_not_full", 64'(rq.full_o), 64'd0);

      // 5: flush and resolve on an empty queue do nothing
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t5_busy", 64'(rq.busy_o), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t5_count", 64'(rq.count_o), 64'd0);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("t5_restore", 64'(rq.restore_o), 64'd0);

`ifdef RAS_RQ_STATS_EN
      checkOutput("stat_overflow", 64'(rq.stat_overflow_o), 64'd1);
      checkOutput("stat_restored", 64'(rq.stat_restored_o), 64'(pushedTotal));
`endif

      // 6: reset mid-replay aborts at once
      applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h3, 1'b0, 1'b0);
      expectRestore(32'h3);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("t6_restore", 64'(rq.restore_o), 64'd0);
      checkOutput("t6_busy", 64'(rq.busy_o), 64'd0);
      checkOutput("t6_count", 64'(rq.count_o), 64'd0);
      #4;
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("t6_idle_busy", 64'(rq.busy_o), 64'd0);
      checkOutput("t6_idle_count", 64'(rq.count_o), 64'd0);
      checkOutput("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
